// File: rtl/axi4_sram_slave_if.sv
// axi4_if: AXI4 bus bundle with Master and Slave views.
// Widths follow the attached slave's parameters.
interface axi4_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 1
);
  localparam int SW = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_region;
  logic [3:0]                aw_qos;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [SW-1:0]             w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_region;
  logic [3:0]                ar_qos;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
           aw_cache, aw_prot, aw_region, aw_qos, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
           ar_cache, ar_prot, ar_region, ar_qos, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
           aw_cache, aw_prot, aw_region, aw_qos, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
           ar_cache, ar_prot, ar_region, ar_qos, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );
endinterface

// File: rtl/axi4_sram_slave.sv
// axi4_sram_slave: AXI4 SRAM slave, INCR/FIXED/WRAP, single-port array.
// Optional start-address range check: AXI4_SRAM_RANGE_CHECK_EN.
module axi4_sram_slave #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 1,
  parameter int MEM_SIZE_BYTES = 65536,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic  i_clk,
  input  logic  i_rstn,
  axi4_if.Slave AXI4_S
);
  localparam int BYTES = AXI_DATA_WIDTH / 8;
  localparam int BW    = $clog2(BYTES);
  localparam int MW    = $clog2(MEM_SIZE_BYTES);
  localparam int IW    = MW - BW;
  localparam int WORDS = MEM_SIZE_BYTES / BYTES;

  typedef logic [AXI_ADDR_WIDTH-1:0] addr_t;
  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

  state_t                    state;
  logic [AXI_DATA_WIDTH-1:0] mem [WORDS];
  logic [AXI_DATA_WIDTH-1:0] rdata;
  logic [AXI_ID_WIDTH-1:0]   id;
  addr_t                     addr;
  logic [7:0]                len;
  logic [7:0]                cnt;
  logic [2:0]                size;
  logic [1:0]                burst;
  logic                      err;
  logic                      last_wr;

  function automatic logic [IW-1:0] widx(input addr_t a);
    return IW'((a - BASE_ADDR) >> BW);
  endfunction

  logic aw_oob;
  logic ar_oob;
`ifdef AXI4_SRAM_RANGE_CHECK_EN
  addr_t aw_off;
  addr_t ar_off;
  assign aw_off = AXI4_S.aw_addr - BASE_ADDR;
  assign ar_off = AXI4_S.ar_addr - BASE_ADDR;
  assign aw_oob = aw_off >= addr_t'(MEM_SIZE_BYTES);
  assign ar_oob = ar_off >= addr_t'(MEM_SIZE_BYTES);
`else
  assign aw_oob = 1'b0;
  assign ar_oob = 1'b0;
`endif

  // Round-robin: on a tie the channel not granted last time wins.
  logic ar_win;
  logic aw_win;
  logic aw_hs;
  logic ar_hs;
  logic beat_last;
  assign ar_win = AXI4_S.ar_valid && (!AXI4_S.aw_valid || last_wr);
  assign aw_win = AXI4_S.aw_valid && !ar_win;
  assign aw_hs  = (state == IDLE) && aw_win;
  assign ar_hs  = (state == IDLE) && ar_win;
  assign beat_last = (cnt == len);

  assign AXI4_S.aw_ready = aw_hs;
  assign AXI4_S.ar_ready = ar_hs;
  assign AXI4_S.w_ready  = (state == WRITE);
  assign AXI4_S.b_valid  = (state == WRESP);
  assign AXI4_S.b_id     = id;
  assign AXI4_S.b_resp   = {err, 1'b0};
  assign AXI4_S.b_user   = '0;
  assign AXI4_S.r_valid  = (state == READ);
  assign AXI4_S.r_id     = id;
  assign AXI4_S.r_data   = rdata;
  assign AXI4_S.r_resp   = {err, 1'b0};
  assign AXI4_S.r_last   = (state == READ) && beat_last;
  assign AXI4_S.r_user   = '0;

  addr_t incr;
  addr_t wmask;
  addr_t nxt;
  assign incr  = addr_t'(1) << size;
  assign wmask = ((addr_t'(len) + addr_t'(1)) << size) - addr_t'(1);

  always_comb begin
    nxt = addr + incr;
    unique case (1'b1)
      burst == 2'b00: nxt = addr;
      burst == 2'b10: nxt = (addr & ~wmask) | ((addr + incr) & wmask);
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state   <= IDLE;
      rdata   <= '0;
      id      <= '0;
      addr    <= '0;
      len     <= '0;
      cnt     <= '0;
      size    <= '0;
      burst   <= '0;
      err     <= 1'b0;
      last_wr <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (ar_hs) begin
            id      <= AXI4_S.ar_id;
            addr    <= AXI4_S.ar_addr;
            len     <= AXI4_S.ar_len;
            size    <= AXI4_S.ar_size;
            burst   <= AXI4_S.ar_burst;
            cnt     <= '0;
            err     <= ar_oob;
            last_wr <= 1'b0;
            rdata   <= ar_oob ? '0 : mem[widx(AXI4_S.ar_addr)];
            state   <= READ;
          end else if (aw_hs) begin
            id      <= AXI4_S.aw_id;
            addr    <= AXI4_S.aw_addr;
            len     <= AXI4_S.aw_len;
            size    <= AXI4_S.aw_size;
            burst   <= AXI4_S.aw_burst;
            cnt     <= '0;
            err     <= aw_oob;
            last_wr <= 1'b1;
            state   <= WRITE;
          end
        end
        WRITE: begin
          if (AXI4_S.w_valid) begin
            cnt  <= cnt + 8'd1;
            addr <= nxt;
            if (beat_last) state <= WRESP;
          end
        end
        WRESP: begin
          if (AXI4_S.b_ready) state <= IDLE;
        end
        READ: begin
          if (AXI4_S.r_ready) begin
            if (beat_last) begin
              state <= IDLE;
            end else begin
              cnt   <= cnt + 8'd1;
              addr  <= nxt;
              rdata <= err ? '0 : mem[widx(nxt)];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array keeps its contents across reset.
  always_ff @(posedge i_clk) begin
    if (state == WRITE && AXI4_S.w_valid && !err) begin
      for (int b = 0; b < BYTES; b++) begin
        if (AXI4_S.w_strb[b])
          mem[widx(addr)][8*b +: 8] <= AXI4_S.w_data[8*b +: 8];
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{AXI4_S.aw_lock, AXI4_S.aw_cache, AXI4_S.aw_prot,
                       AXI4_S.aw_region, AXI4_S.aw_qos, AXI4_S.aw_user,
                       AXI4_S.ar_lock, AXI4_S.ar_cache, AXI4_S.ar_prot,
                       AXI4_S.ar_region, AXI4_S.ar_qos, AXI4_S.ar_user,
                       AXI4_S.w_last, AXI4_S.w_user};
endmodule

// File: doc/axi4_sram_slave.md
# axi4_sram_slave

AXI4 slave SRAM that terminates one `axi4_if` master port of the SCR1 wrapper, either the instruction port (`AXI4_IMEM`) or the data port (`AXI4_DMEM`). It serves INCR, FIXED and WRAP bursts from a single-port word-wide array and arbitrates reads against writes. It is the on-chip program/data memory directly downstream of the core.

## Interface
- `AXI_ADDR_WIDTH`, 32: address width.
- `AXI_DATA_WIDTH`, 32: data width; equals the memory word width.
- `AXI_ID_WIDTH`, 4: ID width.
- `AXI_USER_WIDTH`, 1: user width.
- `MEM_SIZE_BYTES`, 65536: array size; power of two, multiple of `AXI_DATA_WIDTH/8`.
- `BASE_ADDR`, 0: byte address of word 0; aligned to `MEM_SIZE_BYTES`.
- `i_clk`, in, 1: single clock.
- `i_rstn`, in, 1: reset, asynchronous, active-low.
- `AXI4_S`, `axi4_if.Slave`, parameter widths: full AXI4 slave; `*_region`, `*_qos`, `*_cache`, `*_prot`, `*_lock` and `*_user` inputs are ignored; `b_user`/`r_user` driven 0.

## Operation
- FSM states: IDLE, WRITE, WRESP, READ.
- IDLE:
  - Arbitration: if only one of `aw_valid`/`ar_valid` is high, that channel wins. If both are high, the channel not granted last time wins (round-robin). After reset, read has priority.
  - The winning ready (`aw_ready` or `ar_ready`) is driven high combinationally in the same cycle; the loser's ready stays 0.
  - On AW handshake: capture id, addr, len, size, burst, then go to WRITE.
  - On AR handshake: capture the same fields, read the array at `ar_addr`, then go to READ.
- WRITE:
  - `w_ready`=1.
  - Each W handshake writes the bytes enabled by `w_strb` to the current word, then advances the beat address.
  - Go to WRESP on the handshake where the beat counter equals len. `w_last` is not used for termination.
- WRESP: `b_valid`=1, `b_id`=captured id, `b_resp`=OKAY (see Configuration). Hold until `b_ready`, then go to IDLE.
- READ:
  - `r_valid`=1, `r_data`=registered array output, `r_id`=captured id, `r_last`=(beat counter == len), `r_resp`=OKAY.
  - On an R handshake of a non-last beat: read the next beat address in the same cycle and keep `r_valid` high.
  - On an R handshake of the last beat: go to IDLE.
- Address generation (byte address, increment 2^size):
  - FIXED: the address stays constant.
  - INCR: address += 2^size.
  - WRAP: wrap boundary is (len+1)·2^size, with len ∈ {1,3,7,15}. The address wraps to the aligned lower boundary when it reaches the upper boundary.
- Word index = (addr − `BASE_ADDR`)[log2(MEM_SIZE_BYTES)−1 : log2(bytes/word)]. Without the range check, upper bits are discarded, so addresses wrap modulo `MEM_SIZE_BYTES`.
- Size greater than the bus width, or WRAP with an illegal len, is a protocol violation and is not checked.
- Reset (asynchronous, including mid-burst):
  - State returns to IDLE; all readys and valids, `b_resp`, `r_resp`, `r_last`, `b_id`, `r_id` and `r_data` become 0.
  - Array contents are preserved and are not initialised.
  - A burst in flight is abandoned.

## Timing
- Write: AW handshake at cycle N, so `w_ready` is high from N+1. The last W handshake at cycle M gives `b_valid` at M+1. A single-beat write therefore has `b_valid` at N+2 at the earliest.
- Read: AR handshake at cycle N gives the first `r_valid` at N+1. With `r_ready` held high there is 1 beat per cycle, so the last beat appears at N+1+len.
- Back-to-back: after a B or last-R handshake at cycle K, IDLE is active at K+1, so the next AW/AR can be accepted at K+1.
- Data stability: `r_data`, `r_last` and `b_*` stay stable while valid is high and ready is low.
- Read-after-write: data written in a burst is visible to any AR accepted after that burst's B handshake.

## Configuration
- `AXI4_SRAM_RANGE_CHECK_EN` defined:
  - A burst whose start address lies outside [`BASE_ADDR`, `BASE_ADDR`+`MEM_SIZE_BYTES`) is fully accepted with normal handshake timing.
  - For such a write, all array writes are suppressed and `b_resp`=SLVERR.
  - For such a read, every beat returns `r_data`=0 and `r_resp`=SLVERR.
- Not defined: no check is made; addresses alias modulo `MEM_SIZE_BYTES` and responses are always OKAY.

## Test plan
- Single write then read: write 0xDEADBEEF to 0x100 with `w_strb`=0xF; a read of 0x100 returns 0xDEADBEEF with OKAY and `r_last`=1, and `r_valid` rises 1 cycle after the AR handshake.
- Byte strobe: write 0x11223344 then 0xAABBCCDD with `w_strb`=0x2 to 0x40; a read returns 0x1122CC44.
- INCR len=3 at 0x200 followed by WRAP len=3 at 0x208 (size=2):
  - the INCR burst reads words 0x200–0x20C over 4 consecutive cycles with `r_ready` held high;
  - the WRAP burst reads 0x208, 0x20C, 0x200, 0x204.
- Simultaneous `aw_valid` and `ar_valid` out of reset: read is granted first; on the next conflict the write is granted. `r_ready` low for 3 cycles holds `r_data` stable.
- Reset asserted during beat 2 of a len=7 write: all outputs go to 0 immediately. After release, beats 0–1 are present in memory and beats 2–7 are unchanged.
- With `AXI4_SRAM_RANGE_CHECK_EN` and `BASE_ADDR`=0, `MEM_SIZE_BYTES`=0x10000: a write to 0x10000 returns SLVERR and memory word 0 is unchanged. Without the macro, the same write lands in word 0 with OKAY.
